// File: rtl/h14tx_pkg.sv
// ============================================================================
// Module      : h14tx_pkg
// Description : Shared types and constants for the HDMI 1.4 TX test-pattern
//               path: pattern identifiers, control-FSM states, the solid-fill
//               colour and a helper that advances the pattern id.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package h14tx_pkg;

    // Pattern ids are numbered so that auto-cycling is a 2-bit wrap-around add.
    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_SOLID    = 2'd3
    } pattern_e;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } ctrl_state_e;

    localparam logic [23:0] c_solid_rgb = 24'h808080;
    localparam int          c_num_bars  = 8;
    localparam int          c_cnt_w     = 12;

    // Next pattern in auto-cycle order; PAT_SOLID wraps back to PAT_BARS.
    function automatic pattern_e next_pattern(input pattern_e p);
        return pattern_e'(p + 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/h14tx_pattern_gen.sv
// ============================================================================
// Module      : h14tx_pattern_gen
// Description : Per-pixel colour generator. Maps (pattern, x, y) to a 24-bit
//               RGB value and registers it (one cycle latency). Pixels outside
//               the active area are forced to black.
// Ports       : clk       - pixel clock
//               rst       - synchronous active-high reset (clears rgb)
//               i_pattern - pattern in effect for this pixel
//               i_x, i_y  - pixel coordinates
//               o_rgb     - registered pixel, [2]=R [1]=G [0]=B
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module h14tx_pattern_gen
    import h14tx_pkg::*;
#(
    parameter int Width  = 1280,
    parameter int Height = 720,
    parameter int XW     = 11,
    parameter int YW     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  pattern_e             i_pattern,
    input  logic [XW-1:0]        i_x,
    input  logic [YW-1:0]        i_y,
    output logic [2:0][7:0]      o_rgb
);

    // One extra bit so a dimension equal to 2**XW still compares correctly.
    localparam logic [XW:0] c_width  = (XW+1)'(Width);
    localparam logic [YW:0] c_height = (YW+1)'(Height);

    logic [c_num_bars-1:1] w_ge_edge;
    logic [2:0]            w_bar;
    logic                  w_active;
    logic [2:0][7:0]       w_rgb;
    logic [2:0][7:0]       r_rgb;

    // Bar edges k*Width/8 are elaboration-time constants; one comparator each.
    for (genvar k = 1; k < c_num_bars; k++) begin : g_bar_edge
        localparam logic [XW:0] c_edge = (XW+1)'((k * Width) / c_num_bars);
        assign w_ge_edge[k] = ({1'b0, i_x} >= c_edge);
    end

    // The comparator outputs form a thermometer code; the highest set edge
    // gives the bar index.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < c_num_bars; k++) begin
            if (w_ge_edge[k]) begin
                w_bar = 3'(k);
            end
        end
    end

    assign w_active = ({1'b0, i_x} < c_width) && ({1'b0, i_y} < c_height);

    always_comb begin
        w_rgb = '0;
        case (i_pattern)
            PAT_BARS:     w_rgb = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
            PAT_GRADIENT: w_rgb = {i_x[7:0], i_y[7:0], 8'h00};
            PAT_CHECKER:  w_rgb = (i_x[5] ^ i_y[5]) ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID:    w_rgb = c_solid_rgb;
            default:      w_rgb = '0;
        endcase
        if (!w_active) begin
            w_rgb = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign o_rgb = r_rgb;

endmodule

`default_nettype wire

// File: rtl/h14tx_pattern_seq.sv
// ============================================================================
// Module      : h14tx_pattern_seq
// Description : Test-pattern sequencer. Detects frame start from the pixel
//               coordinates, accepts manual pattern requests (applied at the
//               next frame start) and optionally auto-cycles the pattern every
//               FramesPerPattern frames. Colour generation is delegated to
//               h14tx_pattern_gen.
// Config      : `define H14TX_PATTERN_AUTO_EN to build the frame counter and
//               auto-cycling; otherwise auto_en is ignored.
// Ports       : pixel_clk   - sole clock, rising edge
//               rst         - synchronous active-high reset
//               x, y        - current pixel column / row
//               sel_valid   - manual pattern request
//               sel_pattern - requested pattern id
//               sel_ready   - request accepted when high with sel_valid
//               auto_en     - enable auto-cycling (sampled every cycle)
//               rgb         - pixel out, [2]=R [1]=G [0]=B, 1-cycle latency
//               pattern     - pattern currently driven
//               frame_start - one-cycle pulse after frame start is detected
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module h14tx_pattern_seq
    import h14tx_pkg::*;
#(
    parameter int Width            = 1280,
    parameter int Height           = 720,
    parameter int FramesPerPattern = 60,
    parameter int XW               = 11,
    parameter int YW               = 10
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic              sel_valid,
    input  logic [1:0]        sel_pattern,
    output logic              sel_ready,
    input  logic              auto_en,
    output logic [2:0][7:0]   rgb,
    output logic [1:0]        pattern,
    output logic              frame_start
);

    ctrl_state_e   r_state;
    ctrl_state_e   w_state_nxt;
    pattern_e      r_pattern;
    pattern_e      w_pattern_nxt;
    pattern_e      r_req_id;
    pattern_e      w_req_id_nxt;
    logic [XW-1:0] r_prev_x;
    logic [YW-1:0] r_prev_y;
    logic          r_frame_start;
    logic          w_at_origin;
    logic          w_prev_origin;
    logic          w_fs_det;

`ifdef H14TX_PATTERN_AUTO_EN
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FramesPerPattern - 1);
    logic [c_cnt_w-1:0] r_frame_cnt;
    logic [c_cnt_w-1:0] w_frame_cnt_nxt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = auto_en & (FramesPerPattern > 0);
`endif

    // Frame start is the first cycle at (0,0); holding (0,0) does not retrigger.
    assign w_at_origin   = (x == '0) && (y == '0);
    assign w_prev_origin = (r_prev_x == '0) && (r_prev_y == '0);
    assign w_fs_det      = w_at_origin && !w_prev_origin;

    // ------------------------------------------------------------------------
    // Next-state / next-pattern logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_req_id_nxt  = r_req_id;
        w_pattern_nxt = r_pattern;
`ifdef H14TX_PATTERN_AUTO_EN
        w_frame_cnt_nxt = r_frame_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (sel_valid) begin
                    w_req_id_nxt = pattern_e'(sel_pattern);
                    w_state_nxt  = ST_PENDING;
                end
`ifdef H14TX_PATTERN_AUTO_EN
                // Auto-advance only from IDLE: a request already waiting in
                // PENDING wins over the counter at the same frame start.
                if (w_fs_det && auto_en) begin
                    if (r_frame_cnt == c_cnt_last) begin
                        w_frame_cnt_nxt = '0;
                        w_pattern_nxt   = next_pattern(r_pattern);
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
`endif
            end
            ST_PENDING: begin
                if (w_fs_det) begin
                    w_pattern_nxt = r_req_id;
                    w_state_nxt   = ST_IDLE;
`ifdef H14TX_PATTERN_AUTO_EN
                    w_frame_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pattern     <= PAT_BARS;
            r_req_id      <= PAT_BARS;
            r_frame_start <= 1'b0;
            // Non-origin so a (0,0) straight after reset is a frame start.
            r_prev_x      <= XW'(1);
            r_prev_y      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pattern     <= w_pattern_nxt;
            r_req_id      <= w_req_id_nxt;
            r_frame_start <= w_fs_det;
            r_prev_x      <= x;
            r_prev_y      <= y;
        end
    end

`ifdef H14TX_PATTERN_AUTO_EN
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end
`endif

    // The generator sees the pattern register, so the pixel at the detection
    // cycle still uses the outgoing pattern; the new one applies from the
    // following pixel on.
    h14tx_pattern_gen #(
        .Width  (Width),
        .Height (Height),
        .XW     (XW),
        .YW     (YW)
    ) u_gen (
        .clk       (pixel_clk),
        .rst       (rst),
        .i_pattern (r_pattern),
        .i_x       (x),
        .i_y       (y),
        .o_rgb     (rgb)
    );

    assign sel_ready   = (r_state == ST_IDLE);
    assign pattern     = r_pattern;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_h14tx_pattern_seq.sv
// ============================================================================
// Module      : tb_h14tx_pattern_seq
// Description : Self-checking bench for h14tx_pattern_seq. A behavioural model
//               (pending flag, frame counter, pixel colour function) predicts
//               every output; scenario tasks compare inline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_h14tx_pattern_seq;

    localparam int W   = 1280;
    localparam int H   = 720;
    localparam int FPP = 2;
    localparam int XW  = 11;
    localparam int YW  = 10;
`ifdef H14TX_PATTERN_AUTO_EN
    localparam bit c_auto = 1'b1;
`else
    localparam bit c_auto = 1'b0;
`endif

    logic            pixel_clk = 1'b0;
    logic            rst = 1'b1;
    logic [XW-1:0]   x = '0;
    logic [YW-1:0]   y = '0;
    logic            sel_valid = 1'b0;
    logic [1:0]      sel_pattern = 2'd0;
    logic            sel_ready;
    logic            auto_en = 1'b0;
    logic [2:0][7:0] rgb;
    logic [1:0]      pattern;
    logic            frame_start;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    int          m_pattern = 0;
    int          m_req = 0;
    bit          m_pending = 1'b0;
    int          m_cnt = 0;
    bit          m_prev_origin = 1'b0;
    logic [23:0] e_rgb = '0;
    bit          e_fs = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    h14tx_pattern_seq #(
        .Width            (W),
        .Height           (H),
        .FramesPerPattern (FPP),
        .XW               (XW),
        .YW               (YW)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .sel_valid   (sel_valid),
        .sel_pattern (sel_pattern),
        .sel_ready   (sel_ready),
        .auto_en     (auto_en),
        .rgb         (rgb),
        .pattern     (pattern),
        .frame_start (frame_start)
    );

    function automatic logic [23:0] ref_pixel(input int p, input int xv, input int yv);
        int          b;
        logic [2:0]  bb;
        if (xv >= W || yv >= H) return 24'h0;
        case (p)
            0: begin
                b  = (xv * 8) / W;
                bb = b[2:0];
                return {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}};
            end
            1: return {8'(xv % 256), 8'(yv % 256), 8'h00};
            2: return (((xv / 32) % 2) != ((yv / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h808080;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic apply(input bit r, input int xv, input int yv,
                         input bit sv, input int sp, input bit ae);
        bit org;
        bit fs;
        rst         = r;
        x           = xv[XW-1:0];
        y           = yv[YW-1:0];
        sel_valid   = sv;
        sel_pattern = sp[1:0];
        auto_en     = ae;
        org = (xv == 0) && (yv == 0);
        if (r) begin
            m_pattern = 0; m_req = 0; m_pending = 0; m_cnt = 0;
            m_prev_origin = 0; e_rgb = '0; e_fs = 0;
        end else begin
            fs    = org && !m_prev_origin;
            e_fs  = fs;
            e_rgb = ref_pixel(m_pattern, xv, yv);
            if (!m_pending) begin
                if (sv) begin
                    m_pending = 1; m_req = sp;
                end
                if (c_auto && fs && ae) begin
                    if (m_cnt == FPP - 1) begin
                        m_cnt = 0; m_pattern = (m_pattern + 1) % 4;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end else if (fs) begin
                m_pattern = m_req; m_pending = 0; m_cnt = 0;
            end
            m_prev_origin = org;
        end
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1, 77, 3, 1, 3, 1);
        apply(1, 77, 3, 0, 0, 0);
        n_vec++; if (rgb !== 24'h0) begin n_err++; $display("FAIL reset_rgb got %06h want 000000", rgb); end
        n_vec++; if (pattern !== 2'd0) begin n_err++; $display("FAIL reset_pattern got %0d want 0", pattern); end
        n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", frame_start); end
        n_vec++; if (sel_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", sel_ready); end
    endtask

    task automatic test_bars();
        apply(0, 0, 0, 0, 0, 0);
        n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL bars_first_fs got %b want 1", frame_start); end
        for (int i = 1; i < W; i++) begin
            apply(0, i, 0, 0, 0, 0);
            n_vec++;
            if (rgb !== e_rgb) begin n_err++; $display("FAIL bars_rgb x=%0d got %06h want %06h", i, rgb, e_rgb); end
        end
        n_vec++; if (rgb !== 24'hFFFFFF) begin n_err++; $display("FAIL bars_last got %06h want FFFFFF", rgb); end
    endtask

    task automatic test_manual_select();
        apply(0, 500, 3, 1, 2, 0);
        n_vec++; if (sel_ready !== 1'b0) begin n_err++; $display("FAIL sel_ready_drop got %b want 0", sel_ready); end
        for (int i = 0; i < 4; i++) begin
            apply(0, $urandom_range(1, W - 1), $urandom_range(0, H - 1), 1, 1, 0);
            n_vec++; if (pattern !== 2'd0) begin n_err++; $display("FAIL midframe_pattern got %0d want 0", pattern); end
            n_vec++; if (rgb !== e_rgb) begin n_err++; $display("FAIL midframe_rgb got %06h want %06h", rgb, e_rgb); end
        end
        apply(0, 0, 0, 0, 0, 0);
        n_vec++; if (pattern !== 2'd2) begin n_err++; $display("FAIL select_apply got %0d want 2", pattern); end
        n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL select_fs got %b want 1", frame_start); end
        apply(0, 32, 0, 0, 0, 0);
        n_vec++; if (rgb !== 24'hFFFFFF) begin n_err++; $display("FAIL checker_32_0 got %06h want FFFFFF", rgb); end
        apply(0, 40, 40, 0, 0, 0);
        n_vec++; if (rgb !== e_rgb) begin n_err++; $display("FAIL checker_40_40 got %06h want %06h", rgb, e_rgb); end
    endtask

    task automatic test_bounds();
        int pulses;
        apply(0, 100, 100, 1, 3, 0);
        apply(0, 200, 5, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        n_vec++; if (pattern !== 2'd3) begin n_err++; $display("FAIL solid_apply got %0d want 3", pattern); end
        apply(0, 1300, 10, 0, 0, 0);
        n_vec++; if (rgb !== 24'h0) begin n_err++; $display("FAIL oob_x got %06h want 000000", rgb); end
        apply(0, 5, 720, 0, 0, 0);
        n_vec++; if (rgb !== 24'h0) begin n_err++; $display("FAIL oob_y got %06h want 000000", rgb); end
        apply(0, 5, 719, 0, 0, 0);
        n_vec++; if (rgb !== 24'h808080) begin n_err++; $display("FAIL solid_edge got %06h want 808080", rgb); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            if (frame_start === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL held_origin_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_reset_pending();
        apply(0, 300, 300, 1, 1, 0);
        n_vec++; if (sel_ready !== 1'b0) begin n_err++; $display("FAIL pend_ready got %b want 0", sel_ready); end
        apply(1, 300, 300, 0, 0, 0);
        n_vec++; if (pattern !== 2'd0) begin n_err++; $display("FAIL rst_pend_pattern got %0d want 0", pattern); end
        n_vec++; if (sel_ready !== 1'b1) begin n_err++; $display("FAIL rst_pend_ready got %b want 1", sel_ready); end
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 10, 10, 0, 0, 0);
        n_vec++; if (pattern !== 2'd0) begin n_err++; $display("FAIL request_lost got %0d want 0", pattern); end
    endtask

`ifdef H14TX_PATTERN_AUTO_EN
    task automatic test_auto();
        int exp_seq[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        apply(1, 9, 9, 0, 0, 0);
        for (int f = 0; f < 9; f++) begin
            apply(0, 0, 0, 0, 0, 1);
            n_vec++;
            if (pattern !== exp_seq[f][1:0] || pattern !== m_pattern[1:0])
                begin n_err++; $display("FAIL auto_seq frame=%0d got %0d want %0d", f, pattern, exp_seq[f]); end
            apply(0, 10, 10, 0, 0, 1);
            apply(0, $urandom_range(1, W - 1), $urandom_range(1, H - 1), 0, 0, 1);
        end
    endtask

    task automatic test_priority();
        apply(1, 9, 9, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 50, 50, 1, 3, 1);
        apply(0, 0, 0, 0, 0, 1);
        n_vec++; if (pattern !== 2'd3) begin n_err++; $display("FAIL prio_pattern got %0d want 3", pattern); end
        apply(0, 50, 50, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        n_vec++; if (pattern !== 2'd3) begin n_err++; $display("FAIL prio_cnt_cleared got %0d want 3", pattern); end
        apply(0, 50, 50, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        n_vec++; if (pattern !== 2'd0) begin n_err++; $display("FAIL prio_wrap got %0d want 0", pattern); end
    endtask
`endif

    task automatic test_random();
        int xv;
        int yv;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                xv = 0; yv = 0;
            end else begin
                xv = $urandom_range(0, 1400);
                yv = $urandom_range(0, 760);
            end
            apply(($urandom_range(0, 499) == 0), xv, yv,
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            n_vec++; if (rgb !== e_rgb) begin n_err++; $display("FAIL rand_rgb i=%0d got %06h want %06h", i, rgb, e_rgb); end
            n_vec++; if (frame_start !== e_fs) begin n_err++; $display("FAIL rand_fs i=%0d got %b want %b", i, frame_start, e_fs); end
            n_vec++; if (pattern !== m_pattern[1:0]) begin n_err++; $display("FAIL rand_pattern i=%0d got %0d want %0d", i, pattern, m_pattern); end
            n_vec++; if (sel_ready !== !m_pending) begin n_err++; $display("FAIL rand_ready i=%0d got %b want %b", i, sel_ready, !m_pending); end
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_manual_select();
        test_bounds();
        test_reset_pending();
`ifdef H14TX_PATTERN_AUTO_EN
        test_auto();
        test_priority();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
